// File: rtl/jk_flip_flop_pkg.sv
// Shared JK definitions: operation encoding, next-state rule and reset value.
package jk_pkg;

   // {J,K} pair interpreted as an operation on one stored bit
   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_RESET  = 2'b01,
      JK_SET    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_op_e;

   localparam logic JK_RST_VAL = 1'b0;

   // Next state of a single JK bit given the requested operation
   function automatic logic jk_next(jk_op_e op, logic q);
      jk_next = q;
      case (op)
         JK_HOLD:   jk_next = q;
         JK_RESET:  jk_next = 1'b0;
         JK_SET:    jk_next = 1'b1;
         JK_TOGGLE: jk_next = ~q;
         default:   jk_next = q;
      endcase
   endfunction

endpackage

// File: rtl/jk_flip_flop_if.sv
// J/K inputs and Q state of a WIDTH-bit JK register bank.
interface jk_flip_flop_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] J;
   logic [WIDTH-1:0] K;
   logic [WIDTH-1:0] Q;

   // Driver of J/K, observer of Q
   modport master (output J, output K, input Q);
   // The register bank itself
   modport slave  (input J, input K, output Q);
endinterface

// File: rtl/jk_flip_flop_cell.sv
// One-bit JK cell with synchronous active-low reset.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   jk_op_e op;
   assign op = jk_op_e'({j, k});

   // Reset dominates; otherwise apply the JK operation on every rising edge
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every cell samples pre-edge values.
      if (!rst) begin
         q <= JK_RST_VAL;
      end else begin
         q <= jk_next(op, q);
      end
   end

endmodule

// File: rtl/jk_flip_flop.sv
// WIDTH independent JK flip-flops sharing one clock and synchronous reset.
module jk_flip_flop
   import jk_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic              clk,
   input  logic              rst,
   jk_flip_flop_if.slave     jk
);

   // Reject unsupported widths at elaboration
   if ((WIDTH < 1) || (WIDTH > 64)) begin : g_width_check
      $error("jk_flip_flop: WIDTH must be within 1..64");
   end

   // One cell per bit; bits never interact
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (jk.J[i]),
         .k   (jk.K[i]),
         .q   (jk.Q[i])
      );
   end

endmodule

// File: tb/tb_jk_flip_flop.sv
// Self-checking bench for jk_flip_flop at WIDTH=1 and WIDTH=4.
module tb_jk_flip_flop;

   logic clk;
   logic rst;
   int   tests;
   int   failures;

   jk_flip_flop_if #(.WIDTH(1)) if1 ();
   jk_flip_flop_if #(.WIDTH(4)) if4 ();

   jk_flip_flop #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .jk(if1.slave));
   jk_flip_flop #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .jk(if4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: characteristic equation Q+ = J&~Q | ~K&Q, cleared by reset
   logic [0:0] m1;
   logic [3:0] m4;
   logic       m_valid = 1'b0;

   always @(posedge clk) begin
      if (!rst) begin
         m1      <= '0;
         m4      <= '0;
         m_valid <= 1'b1;
      end else begin
         m1 <= (if1.J & ~m1) | (~if1.K & m1);
         m4 <= (if4.J & ~m4) | (~if4.K & m4);
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         check("model_q1", {63'd0, if1.Q}, {63'd0, m1});
         check("model_q4", {60'd0, if4.Q}, {60'd0, m4});
      end
   end

   // Rising-edge timestamps of the 1-bit output, for the divide-by-2 check
   time rise_t[$];
   always @(posedge if1.Q[0]) rise_t.push_back($time);

   // Drive inputs after a falling edge, then wait until just after the next rising edge
   task automatic step(input logic j1, input logic k1,
                       input logic [3:0] j4, input logic [3:0] k4, input logic r);
      @(negedge clk);
      if1.J = j1;
      if1.K = k1;
      if4.J = j4;
      if4.K = k4;
      rst   = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests    = 0;
      failures = 0;
      rst      = 1'b0;
      if1.J    = 1'b1;
      if1.K    = 1'b1;
      if4.J    = 4'b0000;
      if4.K    = 4'b0000;

      // Reset dominates a toggle request
      @(posedge clk); #1;
      check("reset_edge1", {63'd0, if1.Q}, 64'd0);
      check("reset_edge1_w4", {60'd0, if4.Q}, 64'd0);
      @(posedge clk); #1;
      check("reset_edge2", {63'd0, if1.Q}, 64'd0);
      step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
      check("release_hold", {63'd0, if1.Q}, 64'd0);

      // Truth table from Q=0
      step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
      check("tt_set", {63'd0, if1.Q}, 64'd1);
      step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
      check("tt_hold1", {63'd0, if1.Q}, 64'd1);
      step(1'b0, 1'b1, 4'b0000, 4'b0000, 1'b1);
      check("tt_reset", {63'd0, if1.Q}, 64'd0);
      step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
      check("tt_hold0", {63'd0, if1.Q}, 64'd0);

      // Sustained toggle: 1,0,1,0 with a 20-unit period
      rise_t.delete();
      step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      check("toggle1", {63'd0, if1.Q}, 64'd1);
      step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      check("toggle2", {63'd0, if1.Q}, 64'd0);
      step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      check("toggle3", {63'd0, if1.Q}, 64'd1);
      step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      check("toggle4", {63'd0, if1.Q}, 64'd0);
      check("toggle_rises", 64'(rise_t.size()), 64'd2);
      if (rise_t.size() >= 2)
         check("toggle_period", 64'(rise_t[1] - rise_t[0]), 64'd20);

      // Reset asserted between edges only takes effect at the next edge
      step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
      check("pre_mid_set", {63'd0, if1.Q}, 64'd1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_no_effect", {63'd0, if1.Q}, 64'd1);
      @(posedge clk); #1;
      check("mid_rst_edge", {63'd0, if1.Q}, 64'd0);
      step(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1);
      check("mid_rst_release", {63'd0, if1.Q}, 64'd1);

      // A reset pulse that never spans a rising edge is ignored
      @(negedge clk);
      if1.J = 1'b0;
      if1.K = 1'b0;
      #1 rst = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      check("pulse_between_edges", {63'd0, if1.Q}, 64'd1);

      // Reset in the middle of continuous toggling
      step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      check("rt_toggle0", {63'd0, if1.Q}, 64'd0);
      step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      check("rt_toggle1", {63'd0, if1.Q}, 64'd1);
      step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
      check("rst_during_toggle", {63'd0, if1.Q}, 64'd0);
      step(1'b1, 1'b1, 4'b0000, 4'b0000, 1'b1);
      check("toggle_after_release", {63'd0, if1.Q}, 64'd1);

      // Four independent bits: set, reset, toggle, hold
      step(1'b0, 1'b0, 4'b1010, 4'b0110, 1'b1);
      check("w4_first", {60'd0, if4.Q}, 64'h0A);
      step(1'b0, 1'b0, 4'b1010, 4'b0110, 1'b1);
      check("w4_second", {60'd0, if4.Q}, 64'h08);
      step(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1);
      check("w4_hold", {60'd0, if4.Q}, 64'h08);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
